// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access path:
// size codes decoded by data_memory and the arbiter FSM states.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b001;
    localparam logic [2:0] SZ_H  = 3'b010;
    localparam logic [2:0] SZ_W  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b101;
    localparam logic [2:0] SZ_HU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Stores only know signed-agnostic sizes; loads add the unsigned forms.
    function automatic logic size_legal(input logic we, input logic [2:0] size);
        logic ok;
        ok = (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
        if (!we) begin
            ok = ok || (size == SZ_BU) || (size == SZ_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last
// time takes priority when both ask at once.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Single requester wins outright; a tie goes away from last winner.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// One transaction per three cycles: grant, strobe, respond.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_WORDS_LOG2 = 6,
    parameter bit ADDR_CHECK     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [2:0]        p0_size,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [2:0]        p1_size,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [2:0]        mem_size,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state_q;
    logic              last_q;
    logic              owner_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        size_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [1:0]        done_q;

    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_size;
    logic              addr_bad;
    logic              err_d;
    logic              rd_ok;

    rr_arb2 u_arb (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    assign gnt = (state_q == ST_IDLE && !reset) ? arb_gnt : 2'b00;

    assign sel_we    = gnt[1] ? p1_we    : p0_we;
    assign sel_addr  = gnt[1] ? p1_addr  : p0_addr;
    assign sel_wdata = gnt[1] ? p1_wdata : p0_wdata;
    assign sel_size  = gnt[1] ? p1_size  : p0_size;

    generate
        if (ADDR_CHECK) begin : g_chk
            assign addr_bad = |sel_addr[ADDR_W-1:MEM_WORDS_LOG2];
        end else begin : g_nochk
            assign addr_bad = 1'b0;
        end
    endgenerate

    assign err_d = ~size_legal(sel_we, sel_size) | addr_bad;

    // Sequencer: latch the winner in IDLE, strobe in ACCESS, report in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= 3'b000;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 2'b00;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner_q     <= gnt[1];
                        last_q      <= gnt[1];
                        we_q        <= sel_we;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        size_q      <= sel_size;
                        err_q       <= err_d;
                        mem_read_q  <= ~sel_we & ~err_d;
                        mem_write_q <= sel_we & ~err_d;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    done_q  <= owner_q ? 2'b10 : 2'b01;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_ok = ~we_q & ~err_q;

    assign p0_gnt   = gnt[0];
    assign p1_gnt   = gnt[1];
    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p0_err   = done_q[0] & err_q;
    assign p1_err   = done_q[1] & err_q;
    assign p0_rdata = (done_q[0] && rd_ok) ? mem_read_data : '0;
    assign p1_rdata = (done_q[1] && rd_ok) ? mem_read_data : '0;

    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_size       = size_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

endmodule
